// File: rtl/cordic_pkg.sv
// Shared widths and the tag-line record used by the CORDIC request scheduler.
package cordic_pkg;
  localparam int ANGLE_W     = 16;
  localparam int DATA_W      = 24;
  localparam int SEL_W       = 4;
  localparam int SEL_VEC_BIT = 3;
  localparam int TAG_ID_W    = 3;  // holds any requester id for NREQ up to 8

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/cordic_rsp_fifo.sv
// Synchronous response FIFO; the head entry is presented from output registers.
module cordic_rsp_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 51
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       rvalid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    rd_ptr_nx_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nx_s;
  logic [WIDTH-1:0] head_nx_s;
  logic [WIDTH-1:0] rdata_r;
  logic             rvalid_r;
  logic             pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + {{(PW-1){1'b0}}, 1'b1};
  endfunction

  // Next head: a push into an otherwise-draining FIFO bypasses storage.
  always_comb begin
    pop_s       = pop & rvalid_r;
    rd_ptr_nx_s = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
    count_nx_s  = count_r + CW'(push) - CW'(pop_s);
    if (push && ((count_r - CW'(pop_s)) == {CW{1'b0}})) begin
      head_nx_s = wdata;
    end else if (count_nx_s != {CW{1'b0}}) begin
      head_nx_s = mem_r[rd_ptr_nx_s];
    end else begin
      head_nx_s = rdata_r;
    end
  end

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_r[wr_ptr_r] <= wdata;
  end

  // Pointers, occupancy and the registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      rvalid_r <= 1'b0;
      rdata_r  <= {WIDTH{1'b0}};
    end else begin
      if (push) wr_ptr_r <= ptr_inc(wr_ptr_r);
      rd_ptr_r <= rd_ptr_nx_s;
      count_r  <= count_nx_s;
      rvalid_r <= (count_nx_s != {CW{1'b0}});
      rdata_r  <= head_nx_s;
    end
  end

  assign rdata  = rdata_r;
  assign rvalid = rvalid_r;
  assign count  = count_r;
  assign full   = (count_r == CW'(DEPTH));
  assign empty  = (count_r == {CW{1'b0}});
endmodule

// File: rtl/cordic_sched_chk.sv
// Structural invariants of the credited response path.
module cordic_sched_chk #(
  parameter int NREQ       = 4,
  parameter int FIFO_DEPTH = 8
) (
  input logic                            clk,
  input logic                            rst_n,
  input logic                            push,
  input logic                            full,
  input logic [NREQ-1:0]                 grant,
  input logic [$clog2(FIFO_DEPTH+1)-1:0] credit,
  input logic [$clog2(FIFO_DEPTH+1)-1:0] count
);
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
                                   (int'(credit) + int'(count)) <= FIFO_DEPTH);
endmodule

// File: rtl/cordic_sched.sv
// Round-robin front end sharing one CORDIC pipeline among NREQ requesters; results
// return tagged with their origin through a credited FIFO so the pipeline never stalls.
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int PIPE_LAT   = 18,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [16*NREQ-1:0]      req_angle,
  input  logic [16*NREQ-1:0]      req_another,
  input  logic [4*NREQ-1:0]       req_select,
  output logic                    cordic_valid,
  output logic [ANGLE_W-1:0]      cordic_angle,
  output logic [ANGLE_W-1:0]      cordic_another,
  output logic [SEL_W-1:0]        cordic_select,
  input  logic                    res_in_valid,
  input  logic [DATA_W-1:0]       res_in_x,
  input  logic [DATA_W-1:0]       res_in_y,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [DATA_W-1:0]       rsp_x,
  output logic [DATA_W-1:0]       rsp_y,
  output logic                    busy,
  output logic                    err
);
  localparam int IDW = $clog2(NREQ);
  localparam int CRW = $clog2(FIFO_DEPTH + 1);
  localparam int RW  = TAG_ID_W + 2 * DATA_W;

  logic [IDW-1:0]     ptr_r;
  logic [IDW-1:0]     issue_id_r;
  logic [IDW-1:0]     grant_id_s;
  logic [NREQ-1:0]    grant_s;
  logic               grant_hit_s;
  logic [CRW-1:0]     credit_r;
  tag_t               tag_r [PIPE_LAT];
  tag_t               tail_s;
  logic               tag_any_s;
  logic               push_s, drop_s, orphan_s, pop_s;
  logic               err_r;
  logic [RW-1:0]      fifo_rdata_s;
  logic               fifo_full_s, fifo_empty_s;
  logic [CRW-1:0]     fifo_count_s;
  logic [ANGLE_W-1:0] angle_s   [NREQ];
  logic [ANGLE_W-1:0] another_s [NREQ];
  logic [SEL_W-1:0]   select_s  [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign angle_s[i]   = req_angle[i*ANGLE_W +: ANGLE_W];
    assign another_s[i] = req_another[i*ANGLE_W +: ANGLE_W];
    assign select_s[i]  = req_select[i*SEL_W +: SEL_W];
  end

  // Search from ptr+1; walking backwards lets the nearest requester win.
  always_comb begin
    grant_id_s  = ptr_r;
    grant_hit_s = 1'b0;
    if (rst_n && (credit_r != {CRW{1'b0}})) begin
      for (int k = NREQ; k >= 1; k--) begin
        grant_id_s  = req_valid[IDW'((int'(ptr_r) + k) % NREQ)] ?
                      IDW'((int'(ptr_r) + k) % NREQ) : grant_id_s;
        grant_hit_s = grant_hit_s | req_valid[IDW'((int'(ptr_r) + k) % NREQ)];
      end
    end else begin
      grant_hit_s = 1'b0;
    end
    grant_s = grant_hit_s ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_id_s) : {NREQ{1'b0}};
  end

  assign req_ready = grant_s;

  // Issue stage: capture the granted operands and advance the pointer on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r          <= IDW'(NREQ - 1);
      issue_id_r     <= {IDW{1'b0}};
      cordic_valid   <= 1'b0;
      cordic_angle   <= {ANGLE_W{1'b0}};
      cordic_another <= {ANGLE_W{1'b0}};
      cordic_select  <= {SEL_W{1'b0}};
    end else begin
      cordic_valid <= grant_hit_s;
      if (grant_hit_s) begin
        ptr_r          <= grant_id_s;
        issue_id_r     <= grant_id_s;
        cordic_angle   <= angle_s[grant_id_s];
        cordic_another <= another_s[grant_id_s];
        cordic_select  <= select_s[grant_id_s];
      end
    end
  end

  // Tag line: slot k carries the id of the op now k+1 stages into the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) tag_r[i] <= {$bits(tag_t){1'b0}};
    end else begin
      tag_r[0] <= '{valid: cordic_valid, id: TAG_ID_W'(issue_id_r)};
      for (int i = 1; i < PIPE_LAT; i++) tag_r[i] <= tag_r[i-1];
    end
  end

  // Any op still travelling through the pipeline.
  always_comb begin
    tag_any_s = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++) tag_any_s = tag_any_s | tag_r[i].valid;
  end

  assign tail_s   = tag_r[PIPE_LAT-1];
  assign push_s   = tail_s.valid & res_in_valid;
  assign drop_s   = tail_s.valid & ~res_in_valid;
  assign orphan_s = ~tail_s.valid & res_in_valid;
  assign pop_s    = rsp_valid & rsp_ready;

  // A lost result frees its reserved slot, otherwise that credit would leak forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_r <= CRW'(FIFO_DEPTH);
      err_r    <= 1'b0;
    end else begin
      credit_r <= credit_r + CRW'(pop_s) + CRW'(drop_s) - CRW'(grant_hit_s);
      err_r    <= err_r | drop_s | orphan_s;
    end
  end

  cordic_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RW)
  ) u_rsp_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push_s),
    .wdata  ({tail_s.id, res_in_x, res_in_y}),
    .pop    (rsp_ready),
    .rdata  (fifo_rdata_s),
    .rvalid (rsp_valid),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s),
    .count  (fifo_count_s)
  );

  cordic_sched_chk #(
    .NREQ       (NREQ),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push_s),
    .full   (fifo_full_s),
    .grant  (grant_s),
    .credit (credit_r),
    .count  (fifo_count_s)
  );

  assign rsp_id = IDW'(fifo_rdata_s[RW-1 -: TAG_ID_W]);
  assign rsp_x  = fifo_rdata_s[2*DATA_W-1 -: DATA_W];
  assign rsp_y  = fifo_rdata_s[DATA_W-1:0];
  assign busy   = tag_any_s | ~fifo_empty_s | cordic_valid;
  assign err    = err_r;
endmodule

// File: tb/tb_cordic_sched.sv
// Directed bench for cordic_sched with a fixed-latency pipeline model that can drop one result.
module tb_cordic_sched;
  localparam int NREQ       = 4;
  localparam int PIPE_LAT   = 18;
  localparam int FIFO_DEPTH = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NREQ-1:0]         req_valid, req_ready;
  logic [16*NREQ-1:0]      req_angle, req_another;
  logic [4*NREQ-1:0]       req_select;
  logic                    cordic_valid;
  logic [15:0]             cordic_angle, cordic_another;
  logic [3:0]              cordic_select;
  logic                    res_in_valid;
  logic [23:0]             res_in_x, res_in_y;
  logic                    rsp_valid, rsp_ready;
  logic [$clog2(NREQ)-1:0] rsp_id;
  logic [23:0]             rsp_x, rsp_y;
  logic                    busy, err;

  int tests_run    = 0;
  int tests_failed = 0;
  int drop_idx     = -1;
  int issue_cnt;
  int exp_q[$];

  always #5 clk = ~clk;

  cordic_sched #(.NREQ(NREQ), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_angle(req_angle), .req_another(req_another), .req_select(req_select),
    .cordic_valid(cordic_valid), .cordic_angle(cordic_angle),
    .cordic_another(cordic_another), .cordic_select(cordic_select),
    .res_in_valid(res_in_valid), .res_in_x(res_in_x), .res_in_y(res_in_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .busy(busy), .err(err)
  );

  // Pipeline model: result appears PIPE_LAT cycles after cordic_valid; x/y echo the operands.
  logic        m_v [PIPE_LAT];
  logic        m_d [PIPE_LAT];
  logic [23:0] m_x [PIPE_LAT];
  logic [23:0] m_y [PIPE_LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        m_v[i] <= 1'b0; m_d[i] <= 1'b0; m_x[i] <= 24'h0; m_y[i] <= 24'h0;
      end
      issue_cnt <= 0;
    end else begin
      m_v[0] <= cordic_valid;
      m_d[0] <= cordic_valid && (issue_cnt == drop_idx);
      m_x[0] <= {8'h00, cordic_angle};
      m_y[0] <= {8'h00, cordic_another};
      if (cordic_valid) issue_cnt <= issue_cnt + 1;
      for (int i = 1; i < PIPE_LAT; i++) begin
        m_v[i] <= m_v[i-1]; m_d[i] <= m_d[i-1]; m_x[i] <= m_x[i-1]; m_y[i] <= m_y[i-1];
      end
    end
  end

  assign res_in_valid = m_v[PIPE_LAT-1] & ~m_d[PIPE_LAT-1];
  assign res_in_x     = m_x[PIPE_LAT-1];
  assign res_in_y     = m_y[PIPE_LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops;
    for (int i = 0; i < NREQ; i++) begin
      req_angle[i*16 +: 16]   = 16'h0100 + 16'(i);
      req_another[i*16 +: 16] = 16'h0200 + 16'(i);
      req_select[i*4 +: 4]    = 4'(i);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    drop_idx  = -1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  // Drain responses against exp_q, each id carrying the operands set_ops gave it.
  task automatic collect(input int budget);
    int n;
    int id;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      if (rsp_valid && rsp_ready) begin
        id = exp_q.pop_front();
        check("rsp_id", 64'(rsp_id), 64'(id));
        check("rsp_x", 64'(rsp_x), 64'(24'h000100 + 24'(id)));
        check("rsp_y", 64'(rsp_y), 64'(24'h000200 + 24'(id)));
      end
      tick;
      n++;
    end
    check("rsp_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick;
      n++;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    int cnt;
    int accepts;
    int stale;

    // Reset state, with requests already pending.
    rst_n = 1'b0; rsp_ready = 1'b1; req_valid = 4'hF;
    req_angle = '0; req_another = '0; req_select = '0;
    set_ops;
    #3;
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_cvalid", 64'(cordic_valid), 64'h0);
    check("rst_cangle", 64'(cordic_angle), 64'h0);
    check("rst_rvalid", 64'(rsp_valid), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    req_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // Single op from requester 2, angle 45.
    req_angle[2*16 +: 16] = 16'd45;
    req_select[2*4 +: 4]  = 4'h0;
    req_valid = 4'b0100;
    #1;
    check("a_ready", 64'(req_ready), 64'b0100);
    tick;
    req_valid = 4'h0;
    check("a_cvalid", 64'(cordic_valid), 64'd1);
    check("a_cangle", 64'(cordic_angle), 64'd45);
    check("a_csel", 64'(cordic_select), 64'h0);
    check("a_busy", 64'(busy), 64'd1);
    tick;
    check("a_cvalid_pulse", 64'(cordic_valid), 64'd0);
    check("a_cangle_hold", 64'(cordic_angle), 64'd45);
    cnt = 1;
    while (!rsp_valid && cnt < 60) begin
      tick;
      cnt++;
    end
    check("a_latency", 64'(cnt), 64'(PIPE_LAT + 1));
    check("a_rsp_id", 64'(rsp_id), 64'd2);
    check("a_rsp_x", 64'(rsp_x), 64'd45);
    check("a_rsp_y", 64'(rsp_y), 64'h000202);
    tick;
    check("a_idle_valid", 64'(rsp_valid), 64'd0);
    check("a_idle_busy", 64'(busy), 64'd0);

    // Round robin across all requesters for 8 cycles, then credits are gone.
    do_reset;
    set_ops;
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("b_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick;
    end
    check("b_no_credit", 64'(req_ready), 64'h0);
    req_valid = 4'h0;
    for (int k = 0; k < 8; k++) exp_q.push_back(k % 4);
    collect(80);
    wait_idle("b_idle");

    // Consumer stalled: exactly FIFO_DEPTH accepts, one pop buys one more.
    do_reset;
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    accepts = 0;
    for (int k = 0; k < 40; k++) begin
      if (req_ready[1]) accepts++;
      tick;
    end
    check("c_accepts", 64'(accepts), 64'(FIFO_DEPTH));
    check("c_ready_low", 64'(req_ready), 64'h0);
    check("c_rsp_valid", 64'(rsp_valid), 64'd1);
    check("c_rsp_id", 64'(rsp_id), 64'd1);
    rsp_ready = 1'b1;
    #1;
    check("c_ready_during_pop", 64'(req_ready), 64'h0);
    tick;
    rsp_ready = 1'b0;
    check("c_ready_after_pop", 64'(req_ready), 64'b0010);
    tick;
    check("c_ready_relow", 64'(req_ready), 64'h0);

    // Credits at 1: accept and pop in the same cycle keep the grant flowing.
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    tick;
    check("d_credit_one", 64'(dut.credit_r), 64'd1);
    req_valid = 4'b0010;
    #1;
    check("d_ready", 64'(req_ready), 64'b0010);
    check("d_popping", 64'(rsp_valid), 64'd1);
    tick;
    check("d_credit_hold", 64'(dut.credit_r), 64'd1);
    check("d_no_gap", 64'(req_ready), 64'b0010);
    tick;
    check("d_credit_hold2", 64'(dut.credit_r), 64'd1);
    req_valid = 4'h0;
    wait_idle("d_idle");
    check("d_credit_full", 64'(dut.credit_r), 64'(FIFO_DEPTH));
    check("d_err", 64'(err), 64'd0);

    // Pipeline loses the second result: err, credit returned, ids stay aligned.
    do_reset;
    drop_idx = 1;
    set_ops;
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) tick;
    req_valid = 4'h0;
    check("e_err_pre", 64'(err), 64'd0);
    exp_q.push_back(0);
    exp_q.push_back(2);
    exp_q.push_back(3);
    collect(80);
    check("e_err", 64'(err), 64'd1);
    wait_idle("e_idle");
    check("e_credit", 64'(dut.credit_r), 64'(FIFO_DEPTH));

    // Reset with ops in flight and one response waiting.
    do_reset;
    check("f_err_clear", 64'(err), 64'd0);
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) tick;
    req_valid = 4'h0;
    cnt = 0;
    while (!rsp_valid && cnt < 60) begin
      tick;
      cnt++;
    end
    check("f_pre_valid", 64'(rsp_valid), 64'd1);
    check("f_pre_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    check("f_ready", 64'(req_ready), 64'h0);
    check("f_cvalid", 64'(cordic_valid), 64'h0);
    check("f_cangle", 64'(cordic_angle), 64'h0);
    check("f_rvalid", 64'(rsp_valid), 64'h0);
    check("f_rsp_x", 64'(rsp_x), 64'h0);
    check("f_busy", 64'(busy), 64'h0);
    check("f_err", 64'(err), 64'h0);
    req_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (rsp_valid) stale++;
    end
    check("f_stale", 64'(stale), 64'd0);
    check("f_err_after", 64'(err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
